// File: rtl/rect_sbox_seq.sv
// rect_sbox_seq -- column sequencer for the 3-share masked RECTANGLE S-box layer.
//
// Feeds the NCOL four-bit columns of a shared state, one per cycle, into an
// external pipelined masked S-box datapath of fixed latency SBOX_LAT. It then
// scatters the returned output shares back into three state words and pulses
// done when the layer is complete.
//
// Build option: define RAND_REFRESH_EN to add the rnd port. Each issued column
// is then remasked with one fresh byte before it leaves the block.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a layer (honoured in IDLE only)
//   s1, s2, s3            input shares; row r = bits [NCOL*r +: NCOL], column j = bit j
//   rnd                   refresh byte per issued column (RAND_REFRESH_EN only)
//   sb_a..sb_d, sb_vld    issued column, rows 0..3, shares [3:1]
//   sb_q1..sb_q3          returned column shares, bit r = row r
//   o1, o2, o3            output shares, same layout as inputs
//   busy, done            layer in progress / one-cycle completion pulse
module rect_sbox_seq #(
  parameter int NCOL     = 16,
  parameter int SBOX_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*NCOL-1:0]   s1,
  input  logic [4*NCOL-1:0]   s2,
  input  logic [4*NCOL-1:0]   s3,
`ifdef RAND_REFRESH_EN
  input  logic [7:0]          rnd,
`endif
  output logic [2:0]          sb_a,
  output logic [2:0]          sb_b,
  output logic [2:0]          sb_c,
  output logic [2:0]          sb_d,
  output logic                sb_vld,
  input  logic [3:0]          sb_q1,
  input  logic [3:0]          sb_q2,
  input  logic [3:0]          sb_q3,
  output logic [4*NCOL-1:0]   o1,
  output logic [4*NCOL-1:0]   o2,
  output logic [4*NCOL-1:0]   o3,
  output logic                busy,
  output logic                done
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                st;
  logic [CW-1:0]             cnt;
  // Row-major views so a column is simply [row][cnt].
  logic [3:0][NCOL-1:0]      in1, in2, in3;
  logic [3:0][NCOL-1:0]      o1_r, o2_r, o3_r;

  // Stage 0 is the issue cycle; stage SBOX_LAT lines up with sb_q*.
  logic [SBOX_LAT:1]          vld_q;
  logic [SBOX_LAT:1][CW-1:0]  idx_q;
  logic [SBOX_LAT:0]          vld_pipe;
  logic [SBOX_LAT:0][CW-1:0]  idx_pipe;

  logic [3:0][2:0]           col;
  logic [3:0]                r1, r2;

`ifdef RAND_REFRESH_EN
  assign r1 = rnd[3:0];
  assign r2 = rnd[7:4];
`else
  assign r1 = '0;
  assign r2 = '0;
`endif

  // Remasking keeps share1^share2^share3 unchanged: r1 ^ r2 ^ (r1^r2) = 0.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign col[r] = {in3[r][cnt] ^ r1[r] ^ r2[r],
                     in2[r][cnt] ^ r2[r],
                     in1[r][cnt] ^ r1[r]};
  end

  assign sb_vld = (st == FEED);
  assign sb_a   = sb_vld ? col[0] : 3'b0;
  assign sb_b   = sb_vld ? col[1] : 3'b0;
  assign sb_c   = sb_vld ? col[2] : 3'b0;
  assign sb_d   = sb_vld ? col[3] : 3'b0;

  assign vld_pipe = {vld_q, sb_vld};
  assign idx_pipe = {idx_q, cnt};

  assign busy = (st != IDLE);
  assign done = (st == DONE);
  assign o1   = o1_r;
  assign o2   = o2_r;
  assign o3   = o3_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      cnt   <= '0;
      in1   <= '0;
      in2   <= '0;
      in3   <= '0;
      o1_r  <= '0;
      o2_r  <= '0;
      o3_r  <= '0;
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_pipe[SBOX_LAT-1:0];
      idx_q <= idx_pipe[SBOX_LAT-1:0];

      case (st)
        IDLE: if (start) begin
          in1  <= s1;
          in2  <= s2;
          in3  <= s3;
          cnt  <= '0;
          o1_r <= '0;
          o2_r <= '0;
          o3_r <= '0;
          st   <= FEED;
        end
        // Counter parks on the last column rather than wrapping.
        FEED: if (cnt == LAST) st <= DRAIN;
              else             cnt <= cnt + 1'b1;
        // Leave once the last column's return is being captured this cycle.
        DRAIN: if (vld_pipe[SBOX_LAT] && idx_pipe[SBOX_LAT] == LAST) st <= DONE;
        DONE:  st <= IDLE;
        default: st <= IDLE;
      endcase

      // Capture is driven purely by the tracking pipe, independent of st.
      if (vld_pipe[SBOX_LAT]) begin
        for (int r = 0; r < 4; r++) begin
          o1_r[r][idx_pipe[SBOX_LAT]] <= sb_q1[r];
          o2_r[r][idx_pipe[SBOX_LAT]] <= sb_q2[r];
          o3_r[r][idx_pipe[SBOX_LAT]] <= sb_q3[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_sbox_seq.sv
module tb_rect_sbox_seq;
  localparam int NCOL = 16;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] s1, s2, s3, o1, o2, o3;
  logic [2:0]  sb_a, sb_b, sb_c, sb_d;
  logic        sb_vld, busy, done;
  logic [3:0]  sb_q1, sb_q2, sb_q3;
`ifdef RAND_REFRESH_EN
  logic [7:0]  rnd;
`endif

  int checks = 0, errors = 0;
  int cyc = 0;
  int done_cnt, done_cyc, vld_cnt, vld_first, vld_last, busy_cnt;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  rect_sbox_seq #(.NCOL(NCOL), .SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s1(s1), .s2(s2), .s3(s3),
`ifdef RAND_REFRESH_EN
    .rnd(rnd),
`endif
    .sb_a(sb_a), .sb_b(sb_b), .sb_c(sb_c), .sb_d(sb_d), .sb_vld(sb_vld),
    .sb_q1(sb_q1), .sb_q2(sb_q2), .sb_q3(sb_q3),
    .o1(o1), .o2(o2), .o3(o3), .busy(busy), .done(done)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h6; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'hC; 4'h3: sbox = 4'hA;
      4'h4: sbox = 4'h1; 4'h5: sbox = 4'hE; 4'h6: sbox = 4'h7; 4'h7: sbox = 4'h9;
      4'h8: sbox = 4'hB; 4'h9: sbox = 4'h0; 4'hA: sbox = 4'h3; 4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h8; 4'hD: sbox = 4'hF; 4'hE: sbox = 4'h4; default: sbox = 4'h2;
    endcase
  endfunction

  // Unmasked reference: apply the S-box to each column of the combined state.
  function automatic logic [63:0] exp_layer(input logic [63:0] v);
    logic [3:0] x, y;
    exp_layer = '0;
    for (int j = 0; j < NCOL; j++) begin
      for (int r = 0; r < 4; r++) x[r] = v[16*r+j];
      y = sbox(x);
      for (int r = 0; r < 4; r++) exp_layer[16*r+j] = y[r];
    end
  endfunction

  // Expected issued shares {share3,share2,share1} of row r, column j.
  function automatic logic [2:0] issue_col(input logic [63:0] a, b, c, input int j, r);
    issue_col = {c[16*r+j], b[16*r+j], a[16*r+j]};
`ifdef RAND_REFRESH_EN
    issue_col = issue_col ^ {rnd[r] ^ rnd[4+r], rnd[4+r], rnd[r]};
`endif
  endfunction

  // Masked datapath model: unmask, S-box, re-share with fresh random, LAT-cycle delay.
  logic [3:0] p1 [LAT], p2 [LAT], p3 [LAT];
  always @(posedge clk) begin : dp
    logic [3:0] x, m1, m2;
    x  = {^sb_d, ^sb_c, ^sb_b, ^sb_a};
    m1 = 4'($urandom);
    m2 = 4'($urandom);
    p1[0] <= m1;
    p2[0] <= m2;
    p3[0] <= sbox(x) ^ m1 ^ m2;
    for (int k = 1; k < LAT; k++) begin
      p1[k] <= p1[k-1];
      p2[k] <= p2[k-1];
      p3[k] <= p3[k-1];
    end
  end
  assign sb_q1 = p1[LAT-1];
  assign sb_q2 = p2[LAT-1];
  assign sb_q3 = p3[LAT-1];

  // Monitor + scoreboard: pop one expected layer result per done pulse.
  always @(negedge clk) begin : mon
    logic [63:0] want;
    if (rst) exp_q.delete();
    else begin
      if (busy) busy_cnt++;
      if (sb_vld) begin
        if (vld_cnt == 0) vld_first = cyc;
        vld_last = cyc;
        vld_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: done with empty scoreboard, o=%h", o1 ^ o2 ^ o3);
        end else begin
          want = exp_q.pop_front();
          if ((o1 ^ o2 ^ o3) !== want) begin
            errors++;
            $display("FAIL sb_result: got %h expected %h", o1 ^ o2 ^ o3, want);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_obs();
    done_cnt = 0; done_cyc = -1; vld_cnt = 0; vld_first = -1; vld_last = -1; busy_cnt = 0;
  endtask

  // Drives start in the current cycle and returns one cycle later.
  task automatic launch(input logic [63:0] a, b, c);
    s1 = a; s2 = b; s3 = c;
    start = 1'b1;
    exp_q.push_back(exp_layer(a ^ b ^ c));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    while (done_cnt == 0 && cyc < limit) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom}; s3 = {$urandom, $urandom};
    tick(); tick();
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (sb_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b expected 0", sb_vld); end
    checks++; if ({sb_d, sb_c, sb_b, sb_a} !== 12'h0)
      begin errors++; $display("FAIL rst_sb: got %h expected 0", {sb_d, sb_c, sb_b, sb_a}); end
    checks++; if (o1 !== 64'h0) begin errors++; $display("FAIL rst_o1: got %h expected 0", o1); end
    checks++; if (o2 !== 64'h0) begin errors++; $display("FAIL rst_o2: got %h expected 0", o2); end
    checks++; if (o3 !== 64'h0) begin errors++; $display("FAIL rst_o3: got %h expected 0", o3); end
    rst = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    clr_obs(); cyc = 0;
    launch(64'h0, 64'h0, 64'h0);
    wait_done(60);
    tick(); tick(); tick();
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL zero_done_cyc: got %0d expected 19", done_cyc); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (busy_cnt != 19) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 19", busy_cnt); end
    checks++; if ((o1 ^ o2 ^ o3) !== 64'h0000FFFFFFFF0000)
      begin errors++; $display("FAIL zero_result: got %h expected 0000ffffffff0000", o1 ^ o2 ^ o3); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_sb_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_masked();
    logic [63:0] a, b;
    a = 64'h0123456789ABCDEF;
    b = {$urandom, $urandom};
`ifdef RAND_REFRESH_EN
    rnd = 8'($urandom);
`endif
    clr_obs(); cyc = 0;
    launch(a, b, a ^ b);
    checks++; if ({sb_vld, sb_d, sb_c, sb_b, sb_a} !== {1'b1, issue_col(a, b, a ^ b, 0, 3),
        issue_col(a, b, a ^ b, 0, 2), issue_col(a, b, a ^ b, 0, 1), issue_col(a, b, a ^ b, 0, 0)})
      begin errors++; $display("FAIL mask_col0: got %h", {sb_vld, sb_d, sb_c, sb_b, sb_a}); end
    while (cyc < 16) tick();
    checks++; if ({sb_d, sb_c, sb_b, sb_a} !== {issue_col(a, b, a ^ b, 15, 3),
        issue_col(a, b, a ^ b, 15, 2), issue_col(a, b, a ^ b, 15, 1), issue_col(a, b, a ^ b, 15, 0)})
      begin errors++; $display("FAIL mask_col15: got %h", {sb_d, sb_c, sb_b, sb_a}); end
    tick();
    checks++; if ({sb_vld, sb_d, sb_c, sb_b, sb_a} !== 13'h0)
      begin errors++; $display("FAIL mask_drain_idle: got %h expected 0", {sb_vld, sb_d, sb_c, sb_b, sb_a}); end
    wait_done(60);
    tick();
    checks++; if (vld_first != 1 || vld_last != 16 || vld_cnt != 16)
      begin errors++; $display("FAIL mask_vld_window: got first %0d last %0d n %0d expected 1 16 16",
                               vld_first, vld_last, vld_cnt); end
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL mask_done_cyc: got %0d expected 19", done_cyc); end
    checks++; if ((o1 ^ o2 ^ o3) !== 64'h0000FFFFFFFF0000)
      begin errors++; $display("FAIL mask_result: got %h expected 0000ffffffff0000", o1 ^ o2 ^ o3); end
  endtask

  task automatic test_start_busy();
    logic [63:0] a, b, c;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    clr_obs(); cyc = 0;
    launch(a, b, c);
    while (cyc < 25) begin
      tick();
      start = (cyc == 5 || cyc == 19);
      if (start) begin s1 = ~a; s2 = ~b; s3 = c; end
    end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL busy_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL busy_done_cyc: got %0d expected 19", done_cyc); end
    checks++; if (busy_cnt != 19) begin errors++; $display("FAIL busy_cycles: got %0d expected 19", busy_cnt); end
    checks++; if ((o1 ^ o2 ^ o3) !== exp_layer(a ^ b ^ c))
      begin errors++; $display("FAIL busy_hold: got %h expected %h", o1 ^ o2 ^ o3, exp_layer(a ^ b ^ c)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL busy_sb_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    clr_obs(); cyc = 0;
    launch(a, b, 64'h0);
    while (cyc < 12) begin
      tick();
      rst = (cyc == 8);
      if (cyc == 9) begin
        checks++; if (busy !== 1'b0 || sb_vld !== 1'b0)
          begin errors++; $display("FAIL mid_busy: got busy %b vld %b expected 0 0", busy, sb_vld); end
        checks++; if ({o1, o2, o3} !== 192'h0)
          begin errors++; $display("FAIL mid_clear: got %h %h %h expected 0", o1, o2, o3); end
      end
      if (cyc == 11) begin
        checks++; if ({o1, o2, o3} !== 192'h0)
          begin errors++; $display("FAIL mid_no_capture: got %h %h %h expected 0", o1, o2, o3); end
      end
    end
    a = 64'hFEDCBA9876543210; b = {$urandom, $urandom};
    launch(a, b, a ^ b ^ 64'h00FF00FF00FF00FF);
    wait_done(80);
    tick(); tick();
    checks++; if (done_cyc != 31) begin errors++; $display("FAIL mid_done_cyc: got %0d expected 31", done_cyc); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL mid_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if ((o1 ^ o2 ^ o3) !== exp_layer(64'h00FF00FF00FF00FF))
      begin errors++; $display("FAIL mid_result: got %h expected %h", o1 ^ o2 ^ o3, exp_layer(64'h00FF00FF00FF00FF)); end
  endtask

`ifdef RAND_REFRESH_EN
  task automatic test_refresh();
    rnd = 8'hFF;
    clr_obs(); cyc = 0;
    launch(64'h0, 64'h0, 64'h0);
    checks++; if ({sb_d, sb_c, sb_b, sb_a} !== 12'b011_011_011_011)
      begin errors++; $display("FAIL refresh_issue: got %b expected 011011011011", {sb_d, sb_c, sb_b, sb_a}); end
    wait_done(60);
    tick();
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL refresh_done_cyc: got %0d expected 19", done_cyc); end
    checks++; if ((o1 ^ o2 ^ o3) !== 64'h0000FFFFFFFF0000)
      begin errors++; $display("FAIL refresh_result: got %h expected 0000ffffffff0000", o1 ^ o2 ^ o3); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0;
    s1 = '0; s2 = '0; s3 = '0;
`ifdef RAND_REFRESH_EN
    rnd = '0;
`endif
    clr_obs();
    test_reset();
    test_zero();
    test_masked();
    test_start_busy();
    test_reset_mid();
`ifdef RAND_REFRESH_EN
    test_refresh();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
